// File: rtl/jk_sr_pkg.sv
// Shared types and {S,R} decode codes for the J/K set/reset register bank.
package jk_sr_pkg;

   typedef enum logic {
      MODE_JK = 1'b0,
      MODE_SR = 1'b1
   } jk_mode_e;

   localparam int unsigned SR_CODE_W = 2;

   // Codes for the internal {S,R} pair seen by each flop
   localparam logic [SR_CODE_W-1:0] JK_HOLD = 2'b00;
   localparam logic [SR_CODE_W-1:0] JK_SET  = 2'b10;
   localparam logic [SR_CODE_W-1:0] JK_RST  = 2'b01;
   localparam logic [SR_CODE_W-1:0] JK_TGL  = 2'b11;

endpackage : jk_sr_pkg

// File: rtl/jk_sr_cell.sv
// One bit of the bank: J/K or S/R flip-flop with a per-bit reset value.
// In JK mode the {S,R} pair is derived from q, so 11 resolves into a toggle.
// In SR mode a raw 11 holds the bit and is reported as illegal.
module jk_sr_cell
   import jk_sr_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     en,
   input  jk_mode_e mode,
   input  logic     j,
   input  logic     k,
   input  logic     rst_val,
   output logic     q,
   output logic     illegal_bit
);

   logic q_q;
   logic q_d;
   logic s_c;
   logic r_c;

   // Decode {S,R} for the current mode and compute the next bit value
   always_comb begin
      s_c = j;
      r_c = k;
      if (mode == MODE_JK) begin
         s_c = j & ~q_q;
         r_c = k &  q_q;
      end

      q_d = q_q;
      if (en) begin
         case ({s_c, r_c})
            JK_HOLD: q_d = q_q;
            JK_SET:  q_d = 1'b1;
            JK_RST:  q_d = 1'b0;
            // Only reachable in SR mode: the illegal pair holds the bit
            JK_TGL:  q_d = q_q;
         endcase
      end

      illegal_bit = (mode == MODE_SR) & j & k;
   end

   // State register with synchronous reset to the configured value
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= rst_val;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : jk_sr_cell

// File: rtl/jk_sr_reg_bank.sv
// Bank of WIDTH J/K set/reset/toggle flops with run-time JK/SR mode select,
// an illegal-input pulse, a sticky error flag and a saturating error counter.
// Optional macro JK_SR_ERR_CAPTURE_EN adds first_err_mask, the j&k mask of the
// first illegal event since the last reset or error clear.
module jk_sr_reg_bank
   import jk_sr_pkg::*;
#(
   parameter int unsigned           WIDTH     = 8,
   parameter int unsigned           CNT_W     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             illegal,
`ifdef JK_SR_ERR_CAPTURE_EN
   output logic [WIDTH-1:0] first_err_mask,
`endif
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt
);

   jk_mode_e         mode_e;
   logic [WIDTH-1:0] illegal_bits;
   logic             illegal_c;

   logic             illegal_q;
   logic             sticky_q;
   logic             sticky_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign mode_e = jk_mode_e'(mode);

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
      jk_sr_cell u_cell (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .mode        (mode_e),
         .j           (j[i]),
         .k           (k[i]),
         .rst_val     (RESET_VAL[i]),
         .q           (q[i]),
         .illegal_bit (illegal_bits[i])
      );
   end

   assign illegal_c = en & (|illegal_bits);
   assign q_n       = ~q;

   // Error bookkeeping: a same-edge event beats clr_err; counter saturates
   always_comb begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (illegal_c) begin
         sticky_d = 1'b1;
         if (clr_err) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (clr_err) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end
   end

   // Error state registers; illegal is a one-edge pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         illegal_q <= illegal_c;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
      end
   end

   assign illegal    = illegal_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;

`ifdef JK_SR_ERR_CAPTURE_EN
   logic [WIDTH-1:0] mask_q;

   // Capture the mask of the first event since the flag was last clear
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
      end else if (illegal_c && (!sticky_q || clr_err)) begin
         mask_q <= j & k;
      end else if (clr_err) begin
         mask_q <= '0;
      end
   end

   assign first_err_mask = mask_q;
`endif

endmodule : jk_sr_reg_bank
